// File: rtl/aes128_key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller with an 11-entry round-key bank and registered read port.
// Optional zeroize input is enabled by defining AES_KEYSCHED_ZEROIZE_EN.
module aes128_key_schedule_ctrl #(
    parameter int WORDS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
`ifdef AES_KEYSCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic [127:0] rk_out
);

    if (WORDS_PER_CYCLE != 1 && WORDS_PER_CYCLE != 4) begin : g_bad_wpc
        $error("aes128_key_schedule_ctrl: WORDS_PER_CYCLE must be 1 or 4");
    end

    localparam logic [5:0] FIRST_CNT = (WORDS_PER_CYCLE == 4) ? 6'd1  : 6'd4;
    localparam logic [5:0] LAST_CNT  = (WORDS_PER_CYCLE == 4) ? 6'd10 : 6'd43;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t        state, state_nxt;
    logic          done_nxt;
    logic          accept;
    logic          kill;
    logic          wr_en;
    logic          rk_complete;
    logic [5:0]    cnt;
    logic [7:0]    rcon;
    logic [3:0]    wr_idx;
    logic [31:0]   sub_rot;
    logic [31:0]   f_word;
    logic [31:0]   n0, n1, n2, n3;
    logic [127:0]  work_p0;
    logic [127:0]  work_nxt;
    logic [127:0]  bank [0:10];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef AES_KEYSCHED_ZEROIZE_EN
    assign kill = rst | zeroize;
`else
    assign kill = rst;
`endif

    assign key_ready  = (state == S_IDLE) || (state == S_DONE);
    assign busy       = (state == S_EXPAND);
    assign keys_valid = (state == S_DONE);
    assign wr_en      = (state == S_EXPAND) && rk_complete && !kill;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (key_valid) begin
                    state_nxt = S_EXPAND;
                    accept    = !kill;
                end
            end
            S_EXPAND: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single SubWord(RotWord(w[i-1])) lane shared by both widths.
    always_comb begin
        sub_rot     = sub_word({work_p0[23:0], work_p0[31:24]}) ^ {rcon, 24'h0};
        f_word      = work_p0[31:0];
        n0          = work_p0[127:96] ^ sub_rot;
        n1          = work_p0[95:64] ^ n0;
        n2          = work_p0[63:32] ^ n1;
        n3          = work_p0[31:0] ^ n2;
        work_nxt    = work_p0;
        rk_complete = 1'b0;
        wr_idx      = 4'd0;
        if (WORDS_PER_CYCLE == 4) begin
            work_nxt    = {n0, n1, n2, n3};
            rk_complete = 1'b1;
            wr_idx      = cnt[3:0];
        end else begin
            if (cnt[1:0] == 2'd0) f_word = sub_rot;
            work_nxt    = {work_p0[95:0], work_p0[127:96] ^ f_word};
            rk_complete = (cnt[1:0] == 2'd3);
            wr_idx      = cnt[5:2];
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state <= S_IDLE;
            done  <= 1'b0;
            cnt   <= 6'd0;
            rcon  <= 8'h01;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (accept) begin
                cnt  <= FIRST_CNT;
                rcon <= 8'h01;
            end else if (state == S_EXPAND) begin
                cnt <= cnt + 6'd1;
                if (rk_complete) rcon <= xtime(rcon);
            end
        end
    end

    // Working window: the four most recent schedule words w[i-4]..w[i-1].
    always_ff @(posedge clk) begin
        if (accept) work_p0 <= key_in;
        else if (state == S_EXPAND) work_p0 <= work_nxt;
    end

    always_ff @(posedge clk) begin
`ifdef AES_KEYSCHED_ZEROIZE_EN
        if (kill) begin
            for (int i = 0; i < 11; i++) bank[i] <= '0;
        end else
`endif
        if (accept) bank[0] <= key_in;
        else if (wr_en) bank[wr_idx] <= work_nxt;
    end

    always_ff @(posedge clk) begin
        if (kill) rk_out <= '0;
        else if (rk_idx <= 4'd10) rk_out <= bank[rk_idx];
        else rk_out <= '0;
    end

endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Directed bench for aes128_key_schedule_ctrl: runs WPC=4 and WPC=1 instances side by side on shared inputs.
module tb_aes128_key_schedule_ctrl;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic [3:0]   rk_idx;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    logic         zeroize;
`endif
    logic         kr4, busy4, done4, kv4;
    logic         kr1, busy1, done1, kv1;
    logic [127:0] rk4, rk1;

    int passed = 0;
    int total  = 0;

    logic [127:0] fips_rk [11];
    vec_t         tab [16];

    int first4, first1, pulses4, pulses1, rb_bad;

    always #5 clk = ~clk;

    aes128_key_schedule_ctrl #(.WORDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(kr4), .busy(busy4), .done(done4), .keys_valid(kv4),
        .rk_idx(rk_idx),
`ifdef AES_KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .rk_out(rk4)
    );

    aes128_key_schedule_ctrl #(.WORDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(kr1), .busy(busy1), .done(done1), .keys_valid(kv1),
        .rk_idx(rk_idx),
`ifdef AES_KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .rk_out(rk1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs a fixed window, recording first done cycle, done-high count and ready-while-busy cycles.
    // key_valid is released once the WPC=4 instance is ready again.
    task automatic run_window(input int bound);
        first4 = -1; first1 = -1; pulses4 = 0; pulses1 = 0; rb_bad = 0;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (done4) begin
                pulses4++;
                if (first4 < 0) first4 = i;
            end
            if (done1) begin
                pulses1++;
                if (first1 < 0) first1 = i;
            end
            if ((busy4 && kr4) || (busy1 && kr1)) rb_bad++;
            if (key_valid && kr4) key_valid = 1'b0;
        end
    endtask

    initial begin
        fips_rk = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        for (int i = 0; i < 16; i++) begin
            tab[i].idx = 4'(i);
            tab[i].rk  = (i <= 10) ? fips_rk[i] : 128'h0;
        end

        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_idx = 4'd0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick(); tick();
        check("rst_key_ready", {127'h0, kr4}, 128'h1);
        check("rst_busy", {126'h0, busy4, busy1}, 128'h0);
        check("rst_done", {126'h0, done4, done1}, 128'h0);
        check("rst_keys_valid", {126'h0, kv4, kv1}, 128'h0);
        check("rst_rk_out4", rk4, 128'h0);
        check("rst_rk_out1", rk1, 128'h0);
        rst = 1'b0;

        // FIPS key, then a different key held valid throughout expansion
        key_in = KEY_FIPS; key_valid = 1'b1;
        tick();
        check("accept_key_ready", {126'h0, kr4, kr1}, 128'h0);
        check("accept_busy", {126'h0, busy4, busy1}, 128'h3);
        check("accept_keys_valid", {126'h0, kv4, kv1}, 128'h0);
        key_in = KEY_SEQ;
        run_window(50);
        check("latency_wpc4", 128'(first4), 128'd10);
        check("latency_wpc1", 128'(first1), 128'd40);
        check("done_width_wpc4", 128'(pulses4), 128'd1);
        check("done_width_wpc1", 128'(pulses1), 128'd1);
        check("ready_while_busy", 128'(rb_bad), 128'd0);
        check("final_keys_valid", {126'h0, kv4, kv1}, 128'h3);
        check("final_busy", {126'h0, busy4, busy1}, 128'h0);

        foreach (tab[i]) begin
            rk_idx = tab[i].idx;
            tick();
            check($sformatf("rk%0d_wpc4", i), rk4, tab[i].rk);
            check($sformatf("rk%0d_wpc1", i), rk1, tab[i].rk);
        end

        // New key while DONE
        key_in = KEY_SEQ; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("reload_keys_valid_drop", {126'h0, kv4, kv1}, 128'h0);
        run_window(50);
        check("reload_latency_wpc4", 128'(first4), 128'd10);
        check("reload_latency_wpc1", 128'(first1), 128'd40);
        rk_idx = 4'd10; tick();
        check("seq_rk10_wpc4", rk4, SEQ_RK10);
        check("seq_rk10_wpc1", rk1, SEQ_RK10);
        rk_idx = 4'd1; tick();
        check("seq_rk1_wpc4", rk4, SEQ_RK1);
        check("seq_rk1_wpc1", rk1, SEQ_RK1);
        rk_idx = 4'd0; tick();
        check("seq_rk0_wpc4", rk4, KEY_SEQ);

        // Reset five cycles into expansion
        key_in = KEY_FIPS; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_key_ready", {126'h0, kr4, kr1}, 128'h3);
        check("midrst_busy", {126'h0, busy4, busy1}, 128'h0);
        check("midrst_keys_valid", {126'h0, kv4, kv1}, 128'h0);
        run_window(15);
        check("midrst_no_done4", 128'(pulses4), 128'd0);
        check("midrst_no_done1", 128'(pulses1), 128'd0);

        // Reset and key_valid together: key must not be taken
        rst = 1'b1; key_valid = 1'b1; key_in = KEY_SEQ;
        tick();
        rst = 1'b0; key_valid = 1'b0;
        tick();
        check("rst_vs_key_busy", {126'h0, busy4, busy1}, 128'h0);
        check("rst_vs_key_ready", {126'h0, kr4, kr1}, 128'h3);

        key_in = KEY_FIPS; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        run_window(50);
        check("post_rst_latency_wpc4", 128'(first4), 128'd10);
        check("post_rst_latency_wpc1", 128'(first1), 128'd40);
        rk_idx = 4'd10; tick();
        check("post_rst_rk10_wpc4", rk4, fips_rk[10]);
        check("post_rst_rk10_wpc1", rk1, fips_rk[10]);

`ifdef AES_KEYSCHED_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zero_keys_valid", {126'h0, kv4, kv1}, 128'h0);
        check("zero_key_ready", {126'h0, kr4, kr1}, 128'h3);
        check("zero_done", {126'h0, done4, done1}, 128'h0);
        for (int i = 0; i <= 10; i++) begin
            rk_idx = 4'(i);
            tick();
            check($sformatf("zero_rk%0d_wpc4", i), rk4, 128'h0);
            check($sformatf("zero_rk%0d_wpc1", i), rk1, 128'h0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
